// File: rtl/pdm_capture_sequencer_if.sv
// Stereo PCM frame handshake between pdm_capture_sequencer and its consumer.
// PCM_CLIP_DETECT_EN adds the per-frame clip flag.
interface pdm_capture_sequencer_if #(
  parameter int W = 16
) ();
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_left;
  logic [W-1:0] out_right;
`ifdef PCM_CLIP_DETECT_EN
  logic         clip;
`endif

`ifdef PCM_CLIP_DETECT_EN
  modport master (output out_valid, output out_left, output out_right, output clip, input out_ready);
  modport slave  (input out_valid, input out_left, input out_right, input clip, output out_ready);
`else
  modport master (output out_valid, output out_left, output out_right, input out_ready);
  modport slave  (input out_valid, input out_left, input out_right, output out_ready);
`endif
endinterface

// File: rtl/pdm_capture_sequencer.sv
// PDM capture sequencer: PDM mic clock, per-channel sample strobes, CIC comb
// strobe, CIC clear/warm-up handling and stereo frame hand-off.
// Optional feature: define PCM_CLIP_DETECT_EN to add the out_if.clip flag.
module pdm_capture_sequencer #(
  parameter int W       = 16,
  parameter int CLK_DIV = 20,
  parameter int DECIM   = 32,
  parameter int WARMUP  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  output logic                           pdm_clk,
  output logic                           en_left,
  output logic                           en_right,
  output logic                           en_pcm,
  output logic                           cic_reset,
  input  logic [W-1:0]                   pcm_l,
  input  logic [W-1:0]                   pcm_r,
  output logic                           overrun,
  output logic                           busy,
  pdm_capture_sequencer_if.master        out_if
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int DW = $clog2(DECIM);
  localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] CNT_LEFT  = CW'(CLK_DIV / 2 - 3);
  localparam logic [CW-1:0] CNT_RIGHT = CW'(CLK_DIV - 2);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DECIM - 1);
  localparam logic [WW-1:0] WARM_END  = WW'(WARMUP);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_WARM, S_RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [DW-1:0] div;
  logic [WW-1:0] warm;
  logic          timing_on;
  logic          period_end;
  logic          capture;
  logic          frame_free;

  // Strobe and status decodes of the registered state/counters
  always_comb begin
    timing_on  = (state == S_WARM) || (state == S_RUN);
    period_end = timing_on && (cnt == CNT_LAST);
    cnt_nxt    = cnt + CNT_ONE;
    en_left    = timing_on && (cnt == CNT_LEFT);
    en_right   = timing_on && (cnt == CNT_RIGHT);
    en_pcm     = period_end && (div == DIV_LAST);
    // WARMUP=0 makes warm==WARM_END true on the first comb strobe, so that
    // sample is captured without a separate pass-through path.
    capture    = en_pcm && ((state == S_RUN) || (warm == WARM_END));
    frame_free = !out_if.out_valid || out_if.out_ready;
    cic_reset  = (state == S_IDLE) || (state == S_FLUSH);
    busy       = (state != S_IDLE);
  end

  // Sequencer FSM with PDM period / decimation counters and overrun flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      div     <= '0;
      warm    <= '0;
      pdm_clk <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (capture && !frame_free) overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          cnt     <= '0;
          div     <= '0;
          warm    <= '0;
          pdm_clk <= 1'b0;
          if (enable) state <= S_FLUSH;
        end
        S_FLUSH: begin
          overrun <= 1'b0;
          pdm_clk <= 1'b0;
          if (cnt == CNT_ONE) begin
            cnt   <= '0;
            div   <= '0;
            warm  <= '0;
            state <= enable ? S_WARM : S_IDLE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        S_WARM, S_RUN: begin
          if (period_end) begin
            cnt     <= '0;
            pdm_clk <= 1'b0;
            div     <= (div == DIV_LAST) ? '0 : div + 1'b1;
            if (en_pcm && state == S_WARM) begin
              if (warm == WARM_END) state <= S_RUN;
              else                  warm  <= warm + 1'b1;
            end
            // A stop request wins over the warm-up -> run transition
            if (!enable) state <= S_IDLE;
          end else begin
            cnt     <= cnt_nxt;
            pdm_clk <= (cnt_nxt >= CNT_HALF);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PCM_CLIP_DETECT_EN
  localparam logic [W-1:0] PCM_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] PCM_MIN = {1'b1, {(W-1){1'b0}}};
`endif

  // Frame holding register: load on capture when free, clear on accept
  always_ff @(posedge clk) begin
    if (reset) begin
      out_if.out_valid <= 1'b0;
      out_if.out_left  <= '0;
      out_if.out_right <= '0;
`ifdef PCM_CLIP_DETECT_EN
      out_if.clip      <= 1'b0;
`endif
    end else if (capture && frame_free) begin
      out_if.out_valid <= 1'b1;
      out_if.out_left  <= pcm_l;
      out_if.out_right <= pcm_r;
`ifdef PCM_CLIP_DETECT_EN
      out_if.clip      <= (pcm_l == PCM_MAX) || (pcm_l == PCM_MIN) ||
                          (pcm_r == PCM_MAX) || (pcm_r == PCM_MIN);
`endif
    end else if (out_if.out_valid && out_if.out_ready) begin
      out_if.out_valid <= 1'b0;
    end
  end

endmodule
